// File: rtl/special_op_sequencer.sv
// Injects the multi-cycle special opcodes for interrupt entry and RET/RTI completion.
// Optional build macro INT_QUEUE_EN turns the pending flag into a saturating 2-bit request counter.
module special_op_sequencer #(
    parameter int N         = 5,
    parameter int DRAIN_MAX = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         int_req,
    input  logic         one_more_fetch,
    input  logic         fetch_valid,
    input  logic         stall_in,
    input  logic [N-1:0] decoded_op,
    output logic         inject_valid,
    output logic [N-1:0] inject_op,
    output logic         fetch_hold,
    output logic         busy,
    output logic         int_ack,
    output logic         int_pending
);

    localparam int CW = (DRAIN_MAX < 2) ? 1 : $clog2(DRAIN_MAX + 1);

    localparam logic [N-1:0] OP_PUSH_PC_LOW  = N'(5'b10101);
    localparam logic [N-1:0] OP_PUSH_PC_HIGH = N'(5'b10110);
    localparam logic [N-1:0] OP_PUSH_FLAGS   = N'(5'b11111);
    localparam logic [N-1:0] OP_POP_PC_LOW   = N'(5'b10111);
    localparam logic [N-1:0] OP_POP_FLAGS    = N'(5'b01111);
    localparam logic [N-1:0] OP_RET          = N'(5'b11101);
    localparam logic [N-1:0] OP_RTI          = N'(5'b11110);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_PUSH_PC_LOW,
        S_PUSH_PC_HIGH,
        S_PUSH_FLAGS,
        S_POP_PC_LOW,
        S_POP_FLAGS
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   drain_cnt_q, drain_cnt_d;
    logic            rti_flag_q, rti_flag_d;
    logic            int_ack_q, int_ack_d;
    logic            int_req_q;
    logic            entry_done;
    logic            has_pending;
    logic            rise;

`ifdef INT_QUEUE_EN
    logic [1:0]      pend_q, pend_d;
    assign has_pending = (pend_q != 2'd0);
`else
    logic            pend_q, pend_d;
    assign has_pending = pend_q;
`endif

    assign rise = int_req & ~int_req_q;

    always_comb begin
        state_d      = state_q;
        drain_cnt_d  = drain_cnt_q;
        rti_flag_d   = rti_flag_q;
        int_ack_d    = int_ack_q;
        entry_done   = 1'b0;
        inject_valid = 1'b0;
        inject_op    = '0;
        fetch_hold   = 1'b0;

        case (state_q)
            S_PUSH_PC_LOW:  inject_op = OP_PUSH_PC_LOW;
            S_PUSH_PC_HIGH: inject_op = OP_PUSH_PC_HIGH;
            S_PUSH_FLAGS:   inject_op = OP_PUSH_FLAGS;
            S_POP_PC_LOW:   inject_op = OP_POP_PC_LOW;
            S_POP_FLAGS:    inject_op = OP_POP_FLAGS;
            default:        inject_op = '0;
        endcase
        if (state_q != S_IDLE && state_q != S_DRAIN) begin
            inject_valid = 1'b1;
            fetch_hold   = 1'b1;
        end

        // A stall freezes the FSM, the drain counter and the ack pulse.
        if (!stall_in) begin
            int_ack_d = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (decoded_op == OP_RET) begin
                        state_d    = S_POP_PC_LOW;
                        rti_flag_d = 1'b0;
                    end else if (decoded_op == OP_RTI) begin
                        state_d    = S_POP_PC_LOW;
                        rti_flag_d = 1'b1;
                    end else if (has_pending && one_more_fetch) begin
                        state_d     = S_DRAIN;
                        drain_cnt_d = CW'(DRAIN_MAX);
                    end else if (has_pending) begin
                        state_d = S_PUSH_PC_LOW;
                    end
                end
                S_DRAIN: begin
                    if (fetch_valid) begin
                        if (drain_cnt_q <= CW'(1)) begin
                            drain_cnt_d = '0;
                            state_d     = S_PUSH_PC_LOW;
                        end else begin
                            drain_cnt_d = drain_cnt_q - CW'(1);
                        end
                    end
                end
                S_PUSH_PC_LOW:  state_d = S_PUSH_PC_HIGH;
                S_PUSH_PC_HIGH: state_d = S_PUSH_FLAGS;
                S_PUSH_FLAGS: begin
                    state_d    = S_IDLE;
                    entry_done = 1'b1;
                    int_ack_d  = 1'b1;
                end
                S_POP_PC_LOW:   state_d = rti_flag_q ? S_POP_FLAGS : S_IDLE;
                S_POP_FLAGS:    state_d = S_IDLE;
                default:        state_d = S_IDLE;
            endcase
        end
    end

    // A rise landing on the completion edge keeps the request alive.
    always_comb begin
`ifdef INT_QUEUE_EN
        pend_d = pend_q;
        case ({rise, entry_done})
            2'b10:   if (pend_q != 2'd3) pend_d = pend_q + 2'd1;
            2'b01:   pend_d = pend_q - 2'd1;
            default: pend_d = pend_q;
        endcase
`else
        pend_d = rise | (pend_q & ~entry_done);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            drain_cnt_q <= '0;
            rti_flag_q  <= 1'b0;
            int_ack_q   <= 1'b0;
            int_req_q   <= 1'b0;
            pend_q      <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            rti_flag_q  <= rti_flag_d;
            int_ack_q   <= int_ack_d;
            int_req_q   <= int_req;
            pend_q      <= pend_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign int_ack     = int_ack_q;
    assign int_pending = has_pending;

endmodule

// File: tb/tb_special_op_sequencer.sv
// Randomized and directed bench for special_op_sequencer against a script-queue reference model.
module tb_special_op_sequencer;

    localparam int N         = 5;
    localparam int DRAIN_MAX = 1;

    localparam int PL   = 5'b10101;
    localparam int PH   = 5'b10110;
    localparam int PF   = 5'b11111;
    localparam int POPL = 5'b10111;
    localparam int POPF = 5'b01111;
    localparam int RET  = 5'b11101;
    localparam int RTI  = 5'b11110;

    logic         clk;
    logic         reset;
    logic         int_req;
    logic         one_more_fetch;
    logic         fetch_valid;
    logic         stall_in;
    logic [N-1:0] decoded_op;
    logic         inject_valid;
    logic [N-1:0] inject_op;
    logic         fetch_hold;
    logic         busy;
    logic         int_ack;
    logic         int_pending;

    special_op_sequencer #(.N(N), .DRAIN_MAX(DRAIN_MAX)) dut (
        .clk            (clk),
        .reset          (reset),
        .int_req        (int_req),
        .one_more_fetch (one_more_fetch),
        .fetch_valid    (fetch_valid),
        .stall_in       (stall_in),
        .decoded_op     (decoded_op),
        .inject_valid   (inject_valid),
        .inject_op      (inject_op),
        .fetch_hold     (fetch_hold),
        .busy           (busy),
        .int_ack        (int_ack),
        .int_pending    (int_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: the opcodes still to be injected, drain progress, request count.
    int m_seq[$];
    bit m_drain;
    int m_left;
    int m_pend;
    bit m_prev;
    bit m_ack;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit ir, input bit omf, input bit fv,
                              input bit st, input int op);
        bit rise;
        bit done;
        rise   = ir && !m_prev;
        m_prev = ir;
        done   = 1'b0;
        if (r) begin
            m_seq.delete();
            m_drain = 1'b0;
            m_left  = 0;
            m_pend  = 0;
            m_prev  = 1'b0;
            m_ack   = 1'b0;
            return;
        end
        if (!st) begin
            if (m_seq.size() > 0) begin
                int o;
                o = m_seq.pop_front();
                if (o == PF) begin
                    done = 1'b1;
                    $display("txn cycle=%0d interrupt entry complete", cyc);
                end else if (m_seq.size() == 0) begin
                    $display("txn cycle=%0d return sequence complete", cyc);
                end
            end else if (m_drain) begin
                if (fv) begin
                    m_left--;
                    if (m_left <= 0) begin
                        m_drain = 1'b0;
                        m_seq   = {PL, PH, PF};
                    end
                end
            end else if (op == RET) begin
                m_seq = {POPL};
            end else if (op == RTI) begin
                m_seq = {POPL, POPF};
            end else if (m_pend > 0) begin
                if (omf) begin
                    m_drain = 1'b1;
                    m_left  = DRAIN_MAX;
                end else begin
                    m_seq = {PL, PH, PF};
                end
            end
            m_ack = done;
        end
`ifdef INT_QUEUE_EN
        m_pend = m_pend + int'(rise) - int'(done);
        if (m_pend > 3) m_pend = 3;
`else
        if (rise) m_pend = 1;
        else if (done) m_pend = 0;
`endif
    endtask

    task automatic compare_outputs();
        bit iv;
        iv = (m_seq.size() > 0);
        check_eq("inject_valid", int'(inject_valid), int'(iv));
        check_eq("inject_op", int'(inject_op), iv ? m_seq[0] : 0);
        check_eq("fetch_hold", int'(fetch_hold), int'(iv));
        check_eq("busy", int'(busy), int'(iv || m_drain));
        check_eq("int_ack", int'(int_ack), int'(m_ack));
        check_eq("int_pending", int'(int_pending), int'(m_pend != 0));
    endtask

    // Called at a falling edge: drive inputs, clock once, update model, compare at next falling edge.
    task automatic step(input bit r, input bit ir, input bit omf, input bit fv,
                        input bit st, input int op);
        reset          = r;
        int_req        = ir;
        one_more_fetch = omf;
        fetch_valid    = fv;
        stall_in       = st;
        decoded_op     = op[N-1:0];
        @(posedge clk);
        cyc++;
        model_edge(r, ir, omf, fv, st, op);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n, input bit ir);
        for (int i = 0; i < n; i++) step(1'b0, ir, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        reset = 1'b1; int_req = 1'b0; one_more_fetch = 1'b0;
        fetch_valid = 1'b0; stall_in = 1'b0; decoded_op = '0;
        m_drain = 1'b0; m_left = 0; m_pend = 0; m_prev = 1'b0; m_ack = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_eq("reset_busy", int'(busy), 0);
        check_eq("reset_pending", int'(int_pending), 0);

        // Plain interrupt entry with literal expectations.
        idle(1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_eq("s1_pending", int'(int_pending), 1);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_eq("s1_op0", int'(inject_op), PL);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_eq("s1_op1", int'(inject_op), PH);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_eq("s1_op2", int'(inject_op), PF);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_eq("s1_ack", int'(int_ack), 1);
        check_eq("s1_busy", int'(busy), 0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_eq("s1_ack_end", int'(int_ack), 0);
        idle(2, 1'b0);

        // Drain one extra fetch word before entry.
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        check_eq("s2_drain_hold", int'(fetch_hold), 0);
        check_eq("s2_drain_busy", int'(busy), 1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        check_eq("s2_op0", int'(inject_op), PL);
        idle(5, 1'b0);

        // RTI then RET.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RTI);
        check_eq("s3_rti0", int'(inject_op), POPL);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_eq("s3_rti1", int'(inject_op), POPF);
        idle(2, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, RET);
        check_eq("s3_ret0", int'(inject_op), POPL);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check_eq("s3_ret_idle", int'(busy), 0);
        idle(1, 1'b0);

        // RET coincides with an interrupt rise: return first.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, RET);
        check_eq("s4_ret_first", int'(inject_op), POPL);
        idle(7, 1'b1);
        idle(2, 1'b0);

        // Stall for three cycles in PUSH_PC_HIGH.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0);
            check_eq("s5_stall_op", int'(inject_op), PH);
        end
        idle(4, 1'b1);
        idle(1, 1'b0);

        // Reset mid-sequence.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(2, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_eq("s6_valid", int'(inject_valid), 0);
        check_eq("s6_pending", int'(int_pending), 0);
        idle(2, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            bit r, ir, omf, fv, st;
            int op, sel;
            r   = ($urandom_range(0, 99) == 0);
            ir  = ($urandom_range(0, 5) == 0) ? !int_req : int_req;
            omf = ($urandom_range(0, 3) == 0);
            fv  = ($urandom_range(0, 1) == 0);
            st  = ($urandom_range(0, 4) == 0);
            sel = $urandom_range(0, 19);
            op  = (sel == 0) ? RET : (sel == 1) ? RTI : $urandom_range(0, 31);
            step(r, ir, omf, fv, st, op);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/special_op_sequencer.md
Name: special_op_sequencer

Overview:
Sequencer that injects the multi-cycle special opcodes into the fetch-to-decode path for interrupt entry and for RET/RTI completion. It sits between fetch and the decode-stage control unit, holds the PC while an injection runs, and overrides the fetched opcode. The control unit decodes the injected opcodes as ordinary instructions.

Parameters:
N, 5, opcode width
DRAIN_MAX, 1, maximum extra fetch words allowed before interrupt injection starts

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
int_req  in  1  external interrupt request, level; the rising edge is detected internally
one_more_fetch  in  1  the instruction in fetch needs one more word (LDM immediate)
fetch_valid  in  1  fetch stage delivered a word this cycle
stall_in  in  1  pipeline stall from the hazard unit; freezes sequencing
decoded_op  in  N  opcode currently in decode, used to detect RET/RTI
inject_valid  out  1  inject_op replaces the fetched opcode this cycle
inject_op  out  N  injected opcode; 0 (NOP) when inject_valid=0
fetch_hold  out  1  freeze the PC and fetch buffer
busy  out  1  state is not IDLE
int_ack  out  1  one-cycle pulse when the interrupt entry sequence has completed
int_pending  out  1  an interrupt is latched and not yet serviced

Behaviour:
- Opcodes: PUSH_PC_LOW=10101, PUSH_PC_HIGH=10110, PUSH_FLAGS=11111, POP_PC_LOW=10111, POP_FLAGS=01111, RET=11101, RTI=11110.
- Reset: state=IDLE, pending=0, int_req_q=0, drain_cnt=0. All outputs are 0. Reset during a sequence aborts it immediately, with no further injection.
- Edge detect: int_req_q<=int_req. A rise is int_req & ~int_req_q. A rise sets pending on that edge. Further rises while pending=1 merge into the existing request.
- States: IDLE, DRAIN, PUSH_PC_LOW, PUSH_PC_HIGH, PUSH_FLAGS, POP_PC_LOW, POP_FLAGS.
- No transition and no counter change while stall_in=1. Outputs hold their values during the stall.
- IDLE transitions, highest priority first:
  - decoded_op=RET -> POP_PC_LOW, with rti_flag=0.
  - decoded_op=RTI -> POP_PC_LOW, with rti_flag=1.
  - pending=1 and one_more_fetch=1 -> DRAIN, with drain_cnt=DRAIN_MAX.
  - pending=1 otherwise -> PUSH_PC_LOW.
- If return and interrupt coincide, the return runs first and the interrupt stays pending.
- DRAIN: fetch_hold=0 and inject_valid=0. On fetch_valid the counter decrements. When it reaches 0 (same edge as the last decrement), go to PUSH_PC_LOW.
- Injection states: inject_valid=1, inject_op=the state's opcode, fetch_hold=1. Each injection lasts exactly one unstalled cycle.
- Interrupt path: PUSH_PC_LOW -> PUSH_PC_HIGH -> PUSH_FLAGS -> IDLE.
  - On the PUSH_FLAGS exit edge: clear pending and register int_ack=1 for one cycle.
  - A rise arriving on that same edge re-sets pending; set wins over clear.
- Return path:
  - POP_PC_LOW -> POP_FLAGS if rti_flag=1, else -> IDLE.
  - POP_FLAGS -> IDLE.
- Latency: rise sampled at edge t -> pending=1 after t -> PUSH_PC_LOW after edge t+1, i.e. inject_valid is high in the cycle after edge t+1.
- busy=1 in every state except IDLE. int_pending mirrors pending.

Optional Feature:
INT_QUEUE_EN:
- Defined: pending becomes a 2-bit counter, saturating at 3. Each rise increments it and each completed entry decrements it. int_pending = (count != 0). Queued interrupts are serviced back-to-back, with one IDLE cycle between sequences.
- Undefined: a single pending flag; rises while pending are merged.

Test Plan:
- Reset, idle inputs, int_req 0->1 at edge 2 -> PUSH_PC_LOW, PUSH_PC_HIGH, PUSH_FLAGS (10101, 10110, 11111) with inject_valid=1 and fetch_hold=1 in cycles 3-5; int_ack=1 in cycle 6 only; busy low from cycle 6.
- Rise with one_more_fetch=1 -> DRAIN for one cycle with fetch_hold=0; after fetch_valid, the same three-opcode sequence follows.
- decoded_op=11110 (RTI) in IDLE -> 10111 then 01111 injected; decoded_op=11101 (RET) -> 10111 only, then IDLE.
- RET in decode on the same edge as an int_req rise -> 10111 first, then IDLE, then the full interrupt sequence; int_pending stays 1 throughout.
- stall_in=1 for 3 cycles while in PUSH_PC_HIGH -> inject_op stays 10110 for 4 cycles; sequence order unchanged.
- reset=1 while in PUSH_PC_HIGH -> next cycle all outputs 0 and int_pending=0. With INT_QUEUE_EN, three rises produce three back-to-back sequences and three int_ack pulses.
